// File: rtl/dispatch_steer_unit_if.sv
// Rename-to-dispatch bus: the grouped uop input, RS credit returns and per-pipe dispatch outputs.
interface dispatch_steer_unit_if #(
    parameter int DISP_WIDTH  = 2,
    parameter int NUM_PIPES   = 4,
    parameter int QUEUE_DEPTH = 8,
    parameter int UOP_WIDTH   = 64
) ();
    localparam int PW = $clog2(NUM_PIPES);
    localparam int CW = $clog2(QUEUE_DEPTH) + 1;

    logic [DISP_WIDTH-1:0]           in_valid;
    logic [DISP_WIDTH*UOP_WIDTH-1:0] in_uop;
    logic [DISP_WIDTH*PW-1:0]        in_pipe;
    logic                            in_ready;
    logic                            flush;
    logic [NUM_PIPES-1:0]            rs_release;
    logic [NUM_PIPES-1:0]            out_valid;
    logic [NUM_PIPES*UOP_WIDTH-1:0]  out_uop;
    logic [CW-1:0]                   queue_count;
    logic                            credit_err;

    modport master (
        output in_valid, in_uop, in_pipe, flush, rs_release,
        input  in_ready, out_valid, out_uop, queue_count, credit_err
    );

    modport slave (
        input  in_valid, in_uop, in_pipe, flush, rs_release,
        output in_ready, out_valid, out_uop, queue_count, credit_err
    );
endinterface

// File: rtl/dispatch_steer_unit.sv
// In-order dispatch queue that steers up to DISP_WIDTH uops per cycle to execution pipes,
// gated by per-pipe reservation-station credits.
module dispatch_steer_unit #(
    parameter int DISP_WIDTH  = 2,
    parameter int NUM_PIPES   = 4,
    parameter int QUEUE_DEPTH = 8,
    parameter int UOP_WIDTH   = 64,
    parameter int RS_ENTRIES  = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    dispatch_steer_unit_if.slave dsu_bus
);
    localparam int AW  = $clog2(QUEUE_DEPTH);
    localparam int CW  = AW + 1;
    localparam int PW  = $clog2(NUM_PIPES);
    localparam int CRW = $clog2(RS_ENTRIES) + 1;

    localparam logic [CW-1:0]  DEPTH_C = CW'(QUEUE_DEPTH);
    localparam logic [CW-1:0]  GROUP_C = CW'(DISP_WIDTH);
    localparam logic [CRW-1:0] RS_C    = CRW'(RS_ENTRIES);

    logic [UOP_WIDTH-1:0]                  r_mem      [QUEUE_DEPTH];
    logic [PW-1:0]                         r_pipe_mem [QUEUE_DEPTH];
    logic [AW-1:0]                         r_head;
    logic [AW-1:0]                         r_tail;
    logic [CW-1:0]                         r_count;
    logic [NUM_PIPES-1:0][CRW-1:0]         r_credit;
    logic                                  r_credit_err;
    logic [NUM_PIPES-1:0]                  r_out_valid;
    logic [NUM_PIPES-1:0][UOP_WIDTH-1:0]   r_out_uop;

    logic [DISP_WIDTH-1:0][UOP_WIDTH-1:0]  w_in_uop;
    logic [DISP_WIDTH-1:0][PW-1:0]         w_in_pipe;
    logic [CW-1:0]                         w_free;
    logic                                  w_in_ready;
    logic [DISP_WIDTH-1:0]                 w_lane_we;
    logic [DISP_WIDTH-1:0][AW-1:0]         w_lane_slot;
    logic [CW-1:0]                         w_enq_cnt;
    logic [CW-1:0]                         w_disp_cnt;
    logic [NUM_PIPES-1:0]                  w_pipe_used;
    logic [NUM_PIPES-1:0][UOP_WIDTH-1:0]   w_sel_uop;

    assign w_in_uop  = dsu_bus.in_uop;
    assign w_in_pipe = dsu_bus.in_pipe;

    // Space check ignores entries that this cycle's dispatch will free.
    assign w_free     = DEPTH_C - r_count;
    assign w_in_ready = (w_free >= GROUP_C);

    // Compact valid lanes onto consecutive slots starting at the tail.
    always_comb begin
        w_enq_cnt   = '0;
        w_lane_we   = '0;
        w_lane_slot = '0;
        for (int l = 0; l < DISP_WIDTH; l++) begin
            w_lane_slot[l] = r_tail + w_enq_cnt[AW-1:0];
            if (w_in_ready && !dsu_bus.flush && dsu_bus.in_valid[l]) begin
                w_lane_we[l] = 1'b1;
                w_enq_cnt    = w_enq_cnt + CW'(1);
            end else begin
                w_lane_we[l] = 1'b0;
            end
        end
    end

    // Age-ordered dispatch select; the first blocked entry stops everything younger.
    always_comb begin
        logic [AW-1:0] w_idx;
        logic [PW-1:0] w_pipe;
        logic          w_blocked;
        w_disp_cnt  = '0;
        w_pipe_used = '0;
        w_sel_uop   = '0;
        w_idx       = '0;
        w_pipe      = '0;
        w_blocked   = dsu_bus.flush;
        for (int k = 0; k < DISP_WIDTH; k++) begin
            w_idx  = r_head + AW'(k);
            w_pipe = r_pipe_mem[w_idx];
            if (!w_blocked && (CW'(k) < r_count) &&
                (r_credit[w_pipe] != '0) && !w_pipe_used[w_pipe]) begin
                w_pipe_used[w_pipe] = 1'b1;
                w_sel_uop[w_pipe]   = r_mem[w_idx];
                w_disp_cnt          = w_disp_cnt + CW'(1);
            end else begin
                w_blocked = 1'b1;
            end
        end
    end

    // Queue storage; contents behind the head are don't-care, so no reset is needed.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int l = 0; l < DISP_WIDTH; l++) begin
                if (w_lane_we[l]) begin
                    r_mem[w_lane_slot[l]]      <= w_in_uop[l];
                    r_pipe_mem[w_lane_slot[l]] <= w_in_pipe[l];
                end
            end
        end
    end

    // Head/tail/occupancy bookkeeping; pointer adds wrap naturally at AW bits.
    always_ff @(posedge clk) begin
        if (rst || dsu_bus.flush) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            r_head  <= r_head + w_disp_cnt[AW-1:0];
            r_tail  <= r_tail + w_enq_cnt[AW-1:0];
            r_count <= r_count + w_enq_cnt - w_disp_cnt;
        end
    end

    // Per-pipe credits; flush leaves them alone because the RS still returns its entries.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int p = 0; p < NUM_PIPES; p++) begin
                r_credit[p] <= RS_C;
            end
            r_credit_err <= 1'b0;
        end else begin
            for (int p = 0; p < NUM_PIPES; p++) begin
                case ({w_pipe_used[p], dsu_bus.rs_release[p]})
                    2'b10:   r_credit[p] <= r_credit[p] - CRW'(1);
                    2'b01: begin
                        if (r_credit[p] == RS_C) begin
                            r_credit_err <= 1'b1;
                        end else begin
                            r_credit[p] <= r_credit[p] + CRW'(1);
                        end
                    end
                    default: r_credit[p] <= r_credit[p];
                endcase
            end
        end
    end

    // Registered per-pipe dispatch outputs, valid for one cycle only.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid <= '0;
            r_out_uop   <= '0;
        end else begin
            r_out_valid <= w_pipe_used;
            r_out_uop   <= w_sel_uop;
        end
    end

    assign dsu_bus.in_ready    = w_in_ready;
    assign dsu_bus.out_valid   = r_out_valid;
    assign dsu_bus.out_uop     = r_out_uop;
    assign dsu_bus.queue_count = r_count;
    assign dsu_bus.credit_err  = r_credit_err;
endmodule

// File: tb/tb_dispatch_steer_unit.sv
// Self-checking bench for dispatch_steer_unit: directed scenarios plus randomized traffic
// compared against a queue-based reference model.
module tb_dispatch_steer_unit;
    localparam int W  = 2;
    localparam int P  = 4;
    localparam int QD = 8;
    localparam int U  = 64;
    localparam int RS = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    dispatch_steer_unit_if #(.DISP_WIDTH(W), .NUM_PIPES(P), .QUEUE_DEPTH(QD), .UOP_WIDTH(U)) bus ();

    dispatch_steer_unit #(.DISP_WIDTH(W), .NUM_PIPES(P), .QUEUE_DEPTH(QD),
                          .UOP_WIDTH(U), .RS_ENTRIES(RS)) dut (
        .clk(clk), .rst(rst), .dsu_bus(bus)
    );

    typedef struct {
        logic [U-1:0] uop;
        int           pipe;
    } ent_t;

    ent_t         mq[$];
    int           cred[P];
    logic         m_err;
    logic [P-1:0] exp_ov;
    logic [U-1:0] exp_ou[P];
    logic         exp_ready;
    logic         obs_ready;
    int           checks   = 0;
    int           failures = 0;

    function automatic logic model_ready();
        return (QD - mq.size()) >= W;
    endfunction

    function automatic logic [W*U-1:0] rnd_uops();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    task automatic model_reset();
        mq.delete();
        for (int p = 0; p < P; p++) begin
            cred[p]   = RS;
            exp_ou[p] = '0;
        end
        m_err  = 1'b0;
        exp_ov = '0;
    endtask

    task automatic model_step(input logic [W-1:0] v, input logic [W*U-1:0] u,
                              input logic [W*2-1:0] pp, input logic fl, input logic [P-1:0] rel);
        logic [P-1:0] used;
        int n;
        used = '0;
        n = 0;
        exp_ready = model_ready();
        for (int p = 0; p < P; p++) exp_ou[p] = '0;
        if (!fl) begin
            for (int k = 0; k < W && k < mq.size(); k++) begin
                int tp;
                tp = mq[k].pipe;
                if (cred[tp] > 0 && !used[tp]) begin
                    used[tp]   = 1'b1;
                    exp_ou[tp] = mq[k].uop;
                    n++;
                end else begin
                    break;
                end
            end
        end
        exp_ov = used;
        for (int p = 0; p < P; p++) begin
            if (rel[p] && !used[p] && cred[p] == RS) m_err = 1'b1;
            else cred[p] = cred[p] - int'(used[p]) + int'(rel[p]);
        end
        repeat (n) void'(mq.pop_front());
        if (fl) begin
            mq.delete();
        end else if (exp_ready) begin
            for (int l = 0; l < W; l++)
                if (v[l]) mq.push_back('{u[l*U +: U], int'(pp[l*2 +: 2])});
        end
    endtask

    task automatic step(input logic [W-1:0] v, input logic [W*U-1:0] u,
                        input logic [W*2-1:0] pp, input logic fl, input logic [P-1:0] rel);
        bus.in_valid   = v;
        bus.in_uop     = u;
        bus.in_pipe    = pp;
        bus.flush      = fl;
        bus.rs_release = rel;
        @(negedge clk);
        obs_ready = bus.in_ready;
        model_step(v, u, pp, fl, rel);
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        step('0, '0, '0, 1'b0, '0);
    endtask

    task automatic push_group(input logic [W-1:0] v, input logic [W*U-1:0] u, input logic [W*2-1:0] pp);
        for (int g = 0; g < 20 && !model_ready(); g++) idle();
        step(v, u, pp, 1'b0, '0);
    endtask

    task automatic drain_model(input int budget);
        for (int g = 0; g < budget && mq.size() != 0; g++) idle();
        checks++;
        if (mq.size() != 0) begin
            failures++;
            $display("FAIL drain_timeout got=%0d entries left want=0", mq.size());
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.in_valid = '0; bus.in_uop = '0; bus.in_pipe = '0; bus.flush = 1'b0; bus.rs_release = '0;
        @(negedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b want=1", bus.in_ready); end
        checks++; if (bus.queue_count !== 4'd0) begin failures++; $display("FAIL reset_count got=%0d want=0", bus.queue_count); end
        checks++; if (bus.out_valid !== 4'b0) begin failures++; $display("FAIL reset_out_valid got=%b want=0", bus.out_valid); end
        checks++; if (bus.out_uop !== '0) begin failures++; $display("FAIL reset_out_uop got=%h want=0", bus.out_uop); end
        checks++; if (bus.credit_err !== 1'b0) begin failures++; $display("FAIL reset_credit_err got=%b want=0", bus.credit_err); end
        for (int p = 0; p < P; p++) begin
            checks++;
            if (int'(dut.r_credit[p]) != RS) begin failures++; $display("FAIL reset_credit p=%0d got=%0d want=%0d", p, dut.r_credit[p], RS); end
        end
    endtask

    task automatic test_single();
        logic [U-1:0] ua;
        do_reset();
        ua = {$urandom(), $urandom()};
        step(2'b01, {64'd0, ua}, {2'd0, 2'd2}, 1'b0, '0);
        checks++; if (bus.out_valid !== 4'b0000) begin failures++; $display("FAIL single_t1 got=%b want=0000", bus.out_valid); end
        idle();
        checks++; if (bus.out_valid !== 4'b0100) begin failures++; $display("FAIL single_t2_valid got=%b want=0100", bus.out_valid); end
        checks++; if (bus.out_uop[2*U +: U] !== ua) begin failures++; $display("FAIL single_t2_uop got=%h want=%h", bus.out_uop[2*U +: U], ua); end
        checks++; if (int'(dut.r_credit[2]) != 7) begin failures++; $display("FAIL single_credit got=%0d want=7", dut.r_credit[2]); end
        idle();
        checks++; if (bus.out_valid !== 4'b0000) begin failures++; $display("FAIL single_t3 got=%b want=0000", bus.out_valid); end
    endtask

    task automatic test_collision();
        logic [U-1:0] ua, ub;
        do_reset();
        ua = {$urandom(), $urandom()};
        ub = {$urandom(), $urandom()};
        step(2'b11, {ub, ua}, {2'd1, 2'd1}, 1'b0, '0);
        idle();
        checks++; if (bus.out_valid !== 4'b0010 || bus.out_uop[U +: U] !== ua) begin
            failures++; $display("FAIL collision_first got=%b/%h want=0010/%h", bus.out_valid, bus.out_uop[U +: U], ua); end
        idle();
        checks++; if (bus.out_valid !== 4'b0010 || bus.out_uop[U +: U] !== ub) begin
            failures++; $display("FAIL collision_second got=%b/%h want=0010/%h", bus.out_valid, bus.out_uop[U +: U], ub); end
    endtask

    task automatic test_credit_exhaust();
        int n0, n3;
        do_reset();
        n0 = 0; n3 = 0;
        for (int g = 0; g < 5; g++) begin
            push_group(2'b11, rnd_uops(), (g == 4) ? {2'd3, 2'd0} : {2'd0, 2'd0});
            n0 += int'(bus.out_valid[0]); n3 += int'(bus.out_valid[3]);
        end
        for (int c = 0; c < 12; c++) begin
            idle();
            n0 += int'(bus.out_valid[0]); n3 += int'(bus.out_valid[3]);
        end
        checks++; if (n0 != 8) begin failures++; $display("FAIL exhaust_pipe0 got=%0d want=8", n0); end
        checks++; if (n3 != 0) begin failures++; $display("FAIL exhaust_younger_blocked got=%0d want=0", n3); end
        checks++; if (bus.queue_count !== 4'd2) begin failures++; $display("FAIL exhaust_count got=%0d want=2", bus.queue_count); end
        step('0, '0, '0, 1'b0, 4'b0001);
        checks++; if (bus.out_valid !== 4'b0000) begin failures++; $display("FAIL exhaust_hold got=%b want=0000", bus.out_valid); end
        idle();
        checks++; if (bus.out_valid !== 4'b1001 || bus.out_uop[0 +: U] !== exp_ou[0]) begin
            failures++; $display("FAIL exhaust_resume got=%b want=1001", bus.out_valid); end
    endtask

    task automatic test_fill_wrap();
        do_reset();
        for (int i = 0; i < 16; i++)
            push_group(2'b11, rnd_uops(), {2'((2*i+1) % 4), 2'((2*i) % 4)});
        drain_model(40);
        for (int p = 0; p < P; p++) begin
            checks++;
            if (dut.r_credit[p] !== 4'd0) begin failures++; $display("FAIL fill_credit_zero p=%0d got=%0d want=0", p, dut.r_credit[p]); end
        end
        for (int g = 0; g < 4; g++) push_group(2'b11, rnd_uops(), 4'($urandom_range(0, 15)));
        checks++; if (bus.queue_count !== 4'd8) begin failures++; $display("FAIL fill_count got=%0d want=8", bus.queue_count); end
        checks++; if (bus.in_ready !== 1'b0) begin failures++; $display("FAIL fill_in_ready got=%b want=0", bus.in_ready); end
        for (int c = 0; c < 30; c++) begin
            step(2'b11, rnd_uops(), 4'($urandom_range(0, 15)), 1'b0, 4'($urandom_range(0, 15)));
            checks++; if (obs_ready !== exp_ready) begin failures++; $display("FAIL wrap_in_ready c=%0d got=%b want=%b", c, obs_ready, exp_ready); end
            checks++; if (bus.queue_count !== 4'(mq.size())) begin failures++; $display("FAIL wrap_count c=%0d got=%0d want=%0d", c, bus.queue_count, mq.size()); end
            checks++; if (bus.out_valid !== exp_ov) begin failures++; $display("FAIL wrap_out_valid c=%0d got=%b want=%b", c, bus.out_valid, exp_ov); end
            for (int p = 0; p < P; p++) if (exp_ov[p]) begin
                checks++;
                if (bus.out_uop[p*U +: U] !== exp_ou[p]) begin failures++; $display("FAIL wrap_out_uop c=%0d p=%0d got=%h want=%h", c, p, bus.out_uop[p*U +: U], exp_ou[p]); end
            end
        end
    endtask

    task automatic test_flush();
        do_reset();
        for (int g = 0; g < 4; g++) push_group(2'b11, rnd_uops(), 4'b0000);
        drain_model(20);
        push_group(2'b11, rnd_uops(), 4'b0000);
        push_group(2'b11, rnd_uops(), 4'b0000);
        push_group(2'b01, rnd_uops(), 4'b0000);
        checks++; if (bus.queue_count !== 4'd5) begin failures++; $display("FAIL flush_pre_count got=%0d want=5", bus.queue_count); end
        step('0, '0, '0, 1'b0, 4'b0001);
        step(2'b11, rnd_uops(), 4'b0101, 1'b1, '0);
        checks++; if (bus.queue_count !== 4'd0) begin failures++; $display("FAIL flush_count got=%0d want=0", bus.queue_count); end
        checks++; if (bus.out_valid !== 4'b0000) begin failures++; $display("FAIL flush_out_valid got=%b want=0000", bus.out_valid); end
        checks++; if (dut.r_credit[0] !== 4'd1 || dut.r_credit[1] !== 4'd8) begin
            failures++; $display("FAIL flush_credits got=%0d/%0d want=1/8", dut.r_credit[0], dut.r_credit[1]); end
        idle();
        checks++; if (bus.queue_count !== 4'd0 || bus.out_valid !== 4'b0000) begin
            failures++; $display("FAIL flush_enq_dropped got=%0d/%b want=0/0000", bus.queue_count, bus.out_valid); end
    endtask

    task automatic test_overflow();
        do_reset();
        step('0, '0, '0, 1'b0, 4'b0100);
        checks++; if (dut.r_credit[2] !== 4'd8) begin failures++; $display("FAIL ovf_credit got=%0d want=8", dut.r_credit[2]); end
        checks++; if (bus.credit_err !== 1'b1) begin failures++; $display("FAIL ovf_err got=%b want=1", bus.credit_err); end
        repeat (3) idle();
        checks++; if (bus.credit_err !== 1'b1) begin failures++; $display("FAIL ovf_sticky got=%b want=1", bus.credit_err); end
        do_reset();
        checks++; if (bus.credit_err !== 1'b0) begin failures++; $display("FAIL ovf_clear got=%b want=0", bus.credit_err); end
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 300; c++) begin
            logic [P-1:0] rel;
            rel = '0;
            for (int p = 0; p < P; p++) rel[p] = ($urandom_range(0, 2) == 0);
            step(2'($urandom()), rnd_uops(), 4'($urandom()), ($urandom_range(0, 31) == 0), rel);
            checks++; if (obs_ready !== exp_ready) begin failures++; $display("FAIL rand_in_ready c=%0d got=%b want=%b", c, obs_ready, exp_ready); end
            checks++; if (bus.out_valid !== exp_ov) begin failures++; $display("FAIL rand_out_valid c=%0d got=%b want=%b", c, bus.out_valid, exp_ov); end
            for (int p = 0; p < P; p++) if (exp_ov[p]) begin
                checks++;
                if (bus.out_uop[p*U +: U] !== exp_ou[p]) begin failures++; $display("FAIL rand_out_uop c=%0d p=%0d got=%h want=%h", c, p, bus.out_uop[p*U +: U], exp_ou[p]); end
            end
            checks++; if (bus.queue_count !== 4'(mq.size())) begin failures++; $display("FAIL rand_count c=%0d got=%0d want=%0d", c, bus.queue_count, mq.size()); end
            checks++; if (bus.credit_err !== m_err) begin failures++; $display("FAIL rand_err c=%0d got=%b want=%b", c, bus.credit_err, m_err); end
            for (int p = 0; p < P; p++) begin
                checks++;
                if (int'(dut.r_credit[p]) != cred[p]) begin failures++; $display("FAIL rand_credit c=%0d p=%0d got=%0d want=%0d", c, p, dut.r_credit[p], cred[p]); end
            end
        end
        for (int g = 0; g < 3; g++) step(2'b11, rnd_uops(), 4'b0000, 1'b0, '0);
        do_reset();
        checks++; if (bus.queue_count !== 4'd0 || bus.in_ready !== 1'b1) begin
            failures++; $display("FAIL midop_reset got=%0d/%b want=0/1", bus.queue_count, bus.in_ready); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_collision();
        test_credit_exhaust();
        test_fill_wrap();
        test_flush();
        test_overflow();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
